// File: rtl/gpr_access_master_if.sv
// Purpose: bundles the command, response and register-file access signals
//          of gpr_access_master.
// Signals:
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_wdata  command channel
//   rsp_valid/rsp_ready/rsp_data                    response channel
//   gpr_address_in/gpr_address_out/gpr_data_in      to register file
//   gpr_data_out                                    from register file
//   gpr_rd/gpr_wr                                   register file strobes
// Modports: master = controller side, slave = environment side.
interface gpr_access_master_if #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned ADDR_W = 12
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  logic [ADDR_W-1:0] gpr_address_in;
  logic [ADDR_W-1:0] gpr_address_out;
  logic [DATA_W-1:0] gpr_data_in;
  logic [DATA_W-1:0] gpr_data_out;
  logic              gpr_rd;
  logic              gpr_wr;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, gpr_data_out,
    output cmd_ready, rsp_valid, rsp_data,
           gpr_address_in, gpr_address_out, gpr_data_in, gpr_rd, gpr_wr
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, gpr_data_out,
    input  cmd_ready, rsp_valid, rsp_data,
           gpr_address_in, gpr_address_out, gpr_data_in, gpr_rd, gpr_wr
  );
endinterface

// File: rtl/gpr_access_master.sv
// Purpose: initiator-side controller for the general-purpose register file.
//          Accepts read-sum / write commands, sequences gpr_rd / gpr_wr
//          strobes (never both high), and returns read results over a
//          valid/ready response channel. One command outstanding at a time.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - gpr_access_master_if.master (command, response, register file)
// Configuration:
//   GPR_WR_ACK_EN - when defined, each write returns a response carrying
//                   the written data; when undefined writes are silent.
module gpr_access_master #(
  parameter int unsigned DATA_W  = 14,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned RD_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  gpr_access_master_if.master  bus
);

  localparam int unsigned CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

  // Elaboration-time parameter sanity
  if (RD_WAIT < 1) begin : g_bad_rd_wait
    $error("gpr_access_master: RD_WAIT must be >= 1");
  end
  if (ADDR_W != 3 * REG_W) begin : g_bad_addr_w
    $error("gpr_access_master: ADDR_W must equal 3*REG_W");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RSP  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              gpr_rd_q, gpr_rd_d;
  logic              gpr_wr_q, gpr_wr_d;
  logic [ADDR_W-1:0] addr_in_q, addr_in_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      gpr_rd_q    <= 1'b0;
      gpr_wr_q    <= 1'b0;
      addr_in_q   <= '0;
      addr_out_q  <= '0;
      data_in_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      gpr_rd_q    <= gpr_rd_d;
      gpr_wr_q    <= gpr_wr_d;
      addr_in_q   <= addr_in_d;
      addr_out_q  <= addr_out_d;
      data_in_q   <= data_in_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    gpr_rd_d    = gpr_rd_q;
    gpr_wr_d    = gpr_wr_q;
    addr_in_d   = addr_in_q;
    addr_out_d  = addr_out_q;
    data_in_d   = data_in_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          // Address/data registers only ever move on an accepted command
          addr_in_d   = bus.cmd_addr;
          addr_out_d  = bus.cmd_addr;
          data_in_d   = bus.cmd_wdata;
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          if (bus.cmd_op) begin
            gpr_wr_d = 1'b1;
            state_d  = WR;
          end else begin
            gpr_rd_d = 1'b1;
            state_d  = RD;
          end
        end
      end

      RD: begin
        if (cnt_q == CNT_W'(RD_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = CAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      CAP: begin
        // Register file already wraps the sum; pass it through untouched
        rsp_data_d  = bus.gpr_data_out;
        gpr_rd_d    = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end

      WR: begin
        gpr_wr_d = 1'b0;
`ifdef GPR_WR_ACK_EN
        rsp_valid_d = 1'b1;
        rsp_data_d  = data_in_q;
        state_d     = RSP;
`else
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
`endif
      end

      RSP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        gpr_rd_d    = 1'b0;
        gpr_wr_d    = 1'b0;
      end
    endcase
  end

  assign bus.cmd_ready       = cmd_ready_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_data        = rsp_data_q;
  assign bus.gpr_rd          = gpr_rd_q;
  assign bus.gpr_wr          = gpr_wr_q;
  assign bus.gpr_address_in  = addr_in_q;
  assign bus.gpr_address_out = addr_out_q;
  assign bus.gpr_data_in     = data_in_q;

endmodule

// File: tb/tb_gpr_access_master.sv
// Purpose: self-checking bench for gpr_access_master. A behavioural register
//          file answers the DUT's strobes; expected read sums come from a
//          bench-side shadow of every commanded write.
module tb_gpr_access_master;

  localparam int unsigned DATA_W  = 14;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned RD_WAIT = 1;

  logic clk;
  logic rst;
  logic rf_clr;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [DATA_W-1:0] model [16];
  logic [DATA_W-1:0] rf    [16];

  gpr_access_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  gpr_access_master #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .REG_W  (REG_W),
    .RD_WAIT(RD_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: write on gpr_wr, data_out is the wrapped 3-register sum
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (bus.gpr_wr) begin
      rf[bus.gpr_address_in[11:8]] <= bus.gpr_data_in;
    end
  end

  assign bus.gpr_data_out = DATA_W'(rf[bus.gpr_address_out[11:8]] +
                                    rf[bus.gpr_address_out[7:4]] +
                                    rf[bus.gpr_address_out[3:0]]);

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Strobes must never overlap
  always @(negedge clk) begin
    if (!rst) check("rd_wr_mutex", 32'(bus.gpr_rd & bus.gpr_wr), 32'd0);
  end

  function automatic logic [DATA_W-1:0] exp_sum(input logic [ADDR_W-1:0] a);
    return DATA_W'(model[a[11:8]] + model[a[7:4]] + model[a[3:0]]);
  endfunction

  // Entered and left at a negedge with the DUT idle
  task automatic do_write(input logic [3:0] idx, input logic [DATA_W-1:0] data);
    logic [ADDR_W-1:0] a;
    a = {idx, 8'($urandom_range(0, 255))};
    check("wr_accept_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_wdata = data;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("wr_strobe", 32'(bus.gpr_wr), 32'd1);
    check("wr_no_rd", 32'(bus.gpr_rd), 32'd0);
    check("wr_addr_idx", 32'(bus.gpr_address_in[11:8]), 32'(idx));
    check("wr_data", 32'(bus.gpr_data_in), 32'(data));
    check("wr_busy", 32'(bus.cmd_ready), 32'd0);
    model[idx] = data;
    @(negedge clk);
    check("wr_pulse_end", 32'(bus.gpr_wr), 32'd0);
    check("wr_no_rd2", 32'(bus.gpr_rd), 32'd0);
`ifdef GPR_WR_ACK_EN
    check("wr_ack_valid", 32'(bus.rsp_valid), 32'd1);
    check("wr_ack_data", 32'(bus.rsp_data), 32'(data));
    check("wr_ack_busy", 32'(bus.cmd_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("wr_ack_done", 32'(bus.rsp_valid), 32'd0);
    check("wr_ack_ready", 32'(bus.cmd_ready), 32'd1);
`else
    check("wr_no_rsp", 32'(bus.rsp_valid), 32'd0);
    check("wr_ready_back", 32'(bus.cmd_ready), 32'd1);
`endif
  endtask

  // Read-sum with rsp_ready held low for 'hold' cycles once rsp_valid rises
  task automatic do_read(input logic [ADDR_W-1:0] a, input int hold);
    logic [DATA_W-1:0] e;
    e = exp_sum(a);
    check("rd_accept_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b0;
    bus.cmd_addr  = a;
    bus.cmd_wdata = DATA_W'($urandom);
    bus.rsp_ready = (hold == 0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < int'(RD_WAIT) + 1; i++) begin
      check("rd_strobe", 32'(bus.gpr_rd), 32'd1);
      check("rd_no_wr", 32'(bus.gpr_wr), 32'd0);
      check("rd_addr_out", 32'(bus.gpr_address_out), 32'(a));
      check("rd_busy", 32'(bus.cmd_ready), 32'd0);
      check("rd_early_rsp", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end
    check("rd_strobe_end", 32'(bus.gpr_rd), 32'd0);
    check("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rd_rsp_data", 32'(bus.rsp_data), 32'(e));
    for (int i = 0; i < hold; i++) begin
      // Stray write offered while busy must be ignored
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 1'b1;
      bus.cmd_addr  = 12'h000;
      bus.cmd_wdata = 14'h1234;
      @(negedge clk);
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_data", 32'(bus.rsp_data), 32'(e));
      check("hold_busy", 32'(bus.cmd_ready), 32'd0);
      check("hold_no_wr", 32'(bus.gpr_wr), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_done", 32'(bus.rsp_valid), 32'd0);
    check("rsp_idle_ready", 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = '0;
    rst           = 1'b1;
    rf_clr        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_gpr_rd", 32'(bus.gpr_rd), 32'd0);
    check("rst_gpr_wr", 32'(bus.gpr_wr), 32'd0);
    check("rst_addr_in", 32'(bus.gpr_address_in), 32'd0);
    check("rst_addr_out", 32'(bus.gpr_address_out), 32'd0);
    check("rst_data_in", 32'(bus.gpr_data_in), 32'd0);
    rst    = 1'b0;
    rf_clr = 1'b0;
    @(negedge clk);

    // AX, BX, CX
    do_write(4'd0, 14'h0005);
    do_write(4'd1, 14'h0010);
    do_write(4'd2, 14'h3FFF);

    // 5 + 0x10 + 0x3FFF wraps to 0x0014
    do_read(12'h012, 0);
    check("sum_wrap_const", 32'(exp_sum(12'h012)), 32'h0014);

    // Consumer stalls for 5 cycles
    do_read(12'h012, 5);

    // Reset while the read strobe is up
    check("rr_accept_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b0;
    bus.cmd_addr  = 12'h012;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("rr_in_rd", 32'(bus.gpr_rd), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rr_rd_drop", 32'(bus.gpr_rd), 32'd0);
    check("rr_no_rsp", 32'(bus.rsp_valid), 32'd0);
    check("rr_ready", 32'(bus.cmd_ready), 32'd1);
    check("rr_addr_out", 32'(bus.gpr_address_out), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_quiet_rsp", 32'(bus.rsp_valid), 32'd0);
      check("rr_quiet_rd", 32'(bus.gpr_rd), 32'd0);
    end
    do_read(12'h012, 0);

    // DX write: echoed only when write acknowledge is built in
    do_write(4'd3, 14'h1ABC);
    do_read(12'h333, 1);

    // Random interleaved stream
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(4'($urandom_range(0, 15)), DATA_W'($urandom));
      else
        do_read(ADDR_W'($urandom), int'($urandom_range(0, 2)));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
